// File: rtl/mt9v034_pkg.sv
// Shared code words, FSM state and payload types for the MT9V034 sync decoder.
package mt9v034_pkg;

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned TDATA_W = 16;
    localparam int unsigned CNT_W   = 10;

    localparam logic [WORD_W-1:0] PRE0     = 10'h3FF;
    localparam logic [WORD_W-1:0] PRE1     = 10'h000;
    localparam logic [WORD_W-1:0] CODE_SOF = 10'h200;
    localparam logic [WORD_W-1:0] CODE_SOL = 10'h080;
    localparam logic [WORD_W-1:0] CODE_EOL = 10'h100;
    localparam logic [WORD_W-1:0] CODE_EOF = 10'h300;

    typedef enum logic [1:0] {HUNT, IN_LINE, BETWEEN} state_t;

    typedef struct packed {
        logic [TDATA_W-1:0] data;
        logic               tuser;
        logic               tlast;
    } beat_t;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              is_pixel;
    } hold_t;

    function automatic logic is_code(input logic [WORD_W-1:0] w);
        return (w == CODE_SOF) || (w == CODE_SOL) || (w == CODE_EOL) || (w == CODE_EOF);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered head word; the head register counts toward FIFO_DEPTH.
module axis_sync_fifo
    import mt9v034_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  beat_t i_data,
    input  logic  i_ready,
    output beat_t o_data,
    output logic  o_valid,
    output logic  o_full,
    output logic  o_empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    beat_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    beat_t          r_data;
    logic           r_valid;
    logic           r_full;
    logic           r_empty;

    logic           w_pop;
    logic           w_push_ok;
    logic [AW-1:0]  w_rd_next;
    logic [CW-1:0]  w_count_pop;
    logic [CW-1:0]  w_count_next;
    beat_t          w_head;

    // A pop frees its slot before the push is judged, so full+pop+push succeeds.
    always_comb begin
        w_pop        = r_valid && i_ready;
        w_push_ok    = i_push && (!r_full || w_pop);
        w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_pop  = r_count - CW'(w_pop);
        w_count_next = w_count_pop + CW'(w_push_ok);
        w_head       = (w_count_pop == '0) ? i_data : r_mem[w_rd_next];
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_full   <= (w_count_next == CW'(FIFO_DEPTH));
            r_empty  <= (w_count_next == '0);
            if (w_count_next != '0) begin
                r_data <= w_head;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mt9v034_sync_decoder.sv
// Strips MT9V034 embedded sync sequences from the deserialized word stream and
// emits pixels as AXI4-Stream video, with per-frame status counters.
module mt9v034_sync_decoder
    import mt9v034_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned MAX_LINE   = 1023
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [WORD_W-1:0]   s_word,
    input  logic                s_valid,
    output logic [TDATA_W-1:0]  m_axis_tdata,
    output logic                m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic                stat_clear,
    output logic [CNT_W-1:0]    line_length,
    output logic [CNT_W-1:0]    frame_lines,
    output logic [15:0]         frame_count,
    output logic                overflow,
    output logic                sync_error
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LINE);

    state_t             r_state;
    state_t             w_state_next;
    hold_t              r_hold [3];
    logic               r_sof_pending;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [CNT_W-1:0]   r_line_cnt;
    logic [CNT_W-1:0]   r_line_length;
    logic [CNT_W-1:0]   r_frame_lines;
    logic [15:0]        r_frame_count;
    logic               r_overflow;
    logic               r_sync_error;

    logic               w_match;
    logic               w_push;
    beat_t              w_push_beat;
    logic               w_err;
    logic               w_line_done;
    logic               w_frame_done;
    logic               w_line_restart;
    logic               w_frame_restart;
    logic [CNT_W-1:0]   w_pix_now;
    logic [CNT_W-1:0]   w_lines_now;
    logic               w_drop;
    beat_t              w_fifo_out;
    logic               w_fifo_valid;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // The oldest held word is released on every valid word, tagged with tlast when EOL closes it.
    always_comb begin
        w_match           = s_valid && (r_hold[1].word == PRE0) && (r_hold[0].word == PRE1)
                            && is_code(s_word);
        w_push            = s_valid && r_hold[2].is_pixel;
        w_push_beat.data  = {6'b0, r_hold[2].word};
        w_push_beat.tuser = r_sof_pending;
        w_push_beat.tlast = w_match && (s_word == CODE_EOL);
        w_drop            = w_push && w_fifo_full && !(!w_fifo_empty && m_axis_tready);
        w_pix_now         = w_push ? sat_inc(r_pix_cnt) : r_pix_cnt;
        w_lines_now       = w_line_done ? sat_inc(r_line_cnt) : r_line_cnt;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_match) begin
            case (r_state)
                HUNT:    if (s_word == CODE_SOF) w_state_next = IN_LINE;
                IN_LINE: begin
                    if (s_word == CODE_EOL)      w_state_next = BETWEEN;
                    else if (s_word == CODE_EOF) w_state_next = HUNT;
                end
                BETWEEN: begin
                    if (s_word == CODE_SOL || s_word == CODE_SOF) w_state_next = IN_LINE;
                    else if (s_word == CODE_EOF)                  w_state_next = HUNT;
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    // Code actions; EOF inside a line closes the line before closing the frame.
    always_comb begin
        w_err           = 1'b0;
        w_line_done     = 1'b0;
        w_frame_done    = 1'b0;
        w_line_restart  = 1'b0;
        w_frame_restart = 1'b0;
        if (w_match) begin
            case (r_state)
                HUNT: begin
                    if (s_word == CODE_SOF) begin
                        w_line_restart  = 1'b1;
                        w_frame_restart = 1'b1;
                    end
                end
                IN_LINE: begin
                    case (s_word)
                        CODE_EOL: w_line_done = 1'b1;
                        CODE_SOL: begin
                            w_err          = 1'b1;
                            w_line_restart = 1'b1;
                        end
                        CODE_SOF: begin
                            w_err           = 1'b1;
                            w_line_restart  = 1'b1;
                            w_frame_restart = 1'b1;
                        end
                        default: begin
                            w_err        = 1'b1;
                            w_line_done  = 1'b1;
                            w_frame_done = 1'b1;
                        end
                    endcase
                end
                BETWEEN: begin
                    case (s_word)
                        CODE_SOL: w_line_restart = 1'b1;
                        CODE_EOF: w_frame_done   = 1'b1;
                        CODE_SOF: begin
                            w_err           = 1'b1;
                            w_line_restart  = 1'b1;
                            w_frame_restart = 1'b1;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 3; i++) begin
                r_hold[i] <= '0;
            end
            r_sof_pending <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_line_length <= '0;
            r_frame_lines <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            if (w_match) begin
                for (int i = 0; i < 3; i++) begin
                    r_hold[i] <= '0;
                end
            end else if (s_valid) begin
                r_hold[0] <= '{word: s_word, is_pixel: (r_state == IN_LINE)};
                r_hold[1] <= r_hold[0];
                r_hold[2] <= r_hold[1];
            end

            if (w_frame_restart)  r_sof_pending <= 1'b1;
            else if (w_push)      r_sof_pending <= 1'b0;

            if (w_line_restart || w_line_done) r_pix_cnt <= '0;
            else                               r_pix_cnt <= w_pix_now;

            if (w_frame_restart) r_line_cnt <= '0;
            else                 r_line_cnt <= w_lines_now;

            if (w_line_done)  r_line_length <= w_pix_now;
            if (w_frame_done) r_frame_lines <= w_lines_now;

            if (stat_clear)        r_frame_count <= w_frame_done ? 16'd1 : 16'd0;
            else if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;

            if (w_drop)          r_overflow <= 1'b1;
            else if (stat_clear) r_overflow <= 1'b0;

            if (w_err)           r_sync_error <= 1'b1;
            else if (stat_clear) r_sync_error <= 1'b0;
        end
    end

    axis_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_push),
        .i_data  (w_push_beat),
        .i_ready (m_axis_tready),
        .o_data  (w_fifo_out),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign m_axis_tdata  = w_fifo_out.data;
    assign m_axis_tuser  = w_fifo_out.tuser;
    assign m_axis_tlast  = w_fifo_out.tlast;
    assign m_axis_tvalid = w_fifo_valid;
    assign line_length   = r_line_length;
    assign frame_lines   = r_frame_lines;
    assign frame_count   = r_frame_count;
    assign overflow      = r_overflow;
    assign sync_error    = r_sync_error;

endmodule

// File: tb/tb_mt9v034_sync_decoder.sv
// Directed bench for mt9v034_sync_decoder: framing, embedded-data, overflow, errors and reset.
module tb_mt9v034_sync_decoder;
    import mt9v034_pkg::*;

    logic        aclk;
    logic        areset;
    logic [9:0]  s_word;
    logic        s_valid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        stat_clear;
    logic [9:0]  line_length;
    logic [9:0]  frame_lines;
    logic [15:0] frame_count;
    logic        overflow;
    logic        sync_error;

    int total = 0;
    int bad   = 0;
    int base  = 0;
    logic [17:0] q [$];

    mt9v034_sync_decoder #(
        .FIFO_DEPTH (64),
        .MAX_LINE   (1023)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_word        (s_word),
        .s_valid       (s_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .stat_clear    (stat_clear),
        .line_length   (line_length),
        .frame_lines   (frame_lines),
        .frame_count   (frame_count),
        .overflow      (overflow),
        .sync_error    (sync_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Beats accepted at the next rising edge; inputs change only just after rising edges.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready)
            q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] beat(input int k);
        if (base + k < q.size()) return q[base + k];
        return '1;
    endfunction

    task automatic send(input logic [9:0] w);
        @(posedge aclk);
        #1;
        s_valid = 1'b1;
        s_word  = w;
    endtask

    task automatic send_sync(input logic [9:0] code);
        send(PRE0);
        send(PRE1);
        send(code);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
            s_valid = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(posedge aclk);
        #1 stat_clear = 1'b1;
        @(posedge aclk);
        #1 stat_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        areset  = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    initial begin
        areset        = 1'b1;
        s_word        = '0;
        s_valid       = 1'b0;
        m_axis_tready = 1'b1;
        stat_clear    = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_fcount", 32'(frame_count), 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("post_rst_tdata", 32'(m_axis_tdata), 0);
        chk("post_rst_linelen", 32'(line_length), 0);

        // Two lines of four pixels, with first-pixel latency probe
        base = q.size();
        send_sync(CODE_SOF);
        send(10'h011); send(10'h022); send(10'h033); send(10'h044);
        @(negedge aclk);
        chk("lat_before_push", 32'(m_axis_tvalid), 0);
        send(PRE0);
        @(negedge aclk);
        chk("lat_after_push", 32'(m_axis_tvalid), 1);
        chk("lat_first_data", 32'(m_axis_tdata), 32'h011);
        send(PRE1); send(CODE_EOL);
        send_sync(CODE_SOL);
        send(10'h055); send(10'h066); send(10'h077); send(10'h088);
        send_sync(CODE_EOL);
        send_sync(CODE_EOF);
        idle(6);
        chk("f1_beats", 32'(q.size() - base), 8);
        chk("f1_b0", 32'(beat(0)), {16'h011, 1'b1, 1'b0});
        chk("f1_b1", 32'(beat(1)), {16'h022, 1'b0, 1'b0});
        chk("f1_b3", 32'(beat(3)), {16'h044, 1'b0, 1'b1});
        chk("f1_b4", 32'(beat(4)), {16'h055, 1'b0, 1'b0});
        chk("f1_b7", 32'(beat(7)), {16'h088, 1'b0, 1'b1});
        chk("f1_linelen", 32'(line_length), 4);
        chk("f1_flines", 32'(frame_lines), 2);
        chk("f1_fcount", 32'(frame_count), 1);
        chk("f1_syncerr", 32'(sync_error), 0);

        // Preamble-like pixel data stays pixel data
        base = q.size();
        send_sync(CODE_SOF);
        send(10'h3FF); send(10'h000); send(10'h155); send(10'h001);
        send_sync(CODE_EOL);
        send_sync(CODE_EOF);
        idle(6);
        chk("f2_beats", 32'(q.size() - base), 4);
        chk("f2_b0", 32'(beat(0)), {16'h3FF, 1'b1, 1'b0});
        chk("f2_b1", 32'(beat(1)), {16'h000, 1'b0, 1'b0});
        chk("f2_b2", 32'(beat(2)), {16'h155, 1'b0, 1'b0});
        chk("f2_b3", 32'(beat(3)), {16'h001, 1'b0, 1'b1});
        chk("f2_linelen", 32'(line_length), 4);
        chk("f2_fcount", 32'(frame_count), 2);
        chk("f2_syncerr", 32'(sync_error), 0);

        // 70-pixel line against a stalled 64-deep FIFO
        base = q.size();
        m_axis_tready = 1'b0;
        send_sync(CODE_SOF);
        for (int i = 0; i < 70; i++) send(10'(i));
        send_sync(CODE_EOL);
        send_sync(CODE_EOF);
        idle(5);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_no_beats", 32'(q.size() - base), 0);
        chk("ovf_tvalid", 32'(m_axis_tvalid), 1);
        chk("ovf_linelen", 32'(line_length), 70);
        chk("ovf_fcount", 32'(frame_count), 3);
        m_axis_tready = 1'b1;
        idle(80);
        chk("ovf_beats", 32'(q.size() - base), 64);
        chk("ovf_b0", 32'(beat(0)), {16'h000, 1'b1, 1'b0});
        chk("ovf_b63", 32'(beat(63)), {16'h03F, 1'b0, 1'b0});
        chk("ovf_sticky", 32'(overflow), 1);
        pulse_clear();
        @(negedge aclk);
        chk("ovf_cleared", 32'(overflow), 0);
        chk("fcount_cleared", 32'(frame_count), 0);

        // SOL in the middle of a line
        base = q.size();
        send_sync(CODE_SOF);
        send(10'h101); send(10'h102);
        send_sync(CODE_SOL);
        send(10'h111); send(10'h112); send(10'h113);
        send_sync(CODE_EOL);
        send_sync(CODE_EOF);
        idle(6);
        chk("sol_syncerr", 32'(sync_error), 1);
        chk("sol_beats", 32'(q.size() - base), 5);
        chk("sol_b0", 32'(beat(0)), {16'h101, 1'b1, 1'b0});
        chk("sol_b1", 32'(beat(1)), {16'h102, 1'b0, 1'b0});
        chk("sol_b2", 32'(beat(2)), {16'h111, 1'b0, 1'b0});
        chk("sol_b4", 32'(beat(4)), {16'h113, 1'b0, 1'b1});
        chk("sol_linelen", 32'(line_length), 3);
        chk("sol_flines", 32'(frame_lines), 1);
        chk("sol_fcount", 32'(frame_count), 1);
        pulse_clear();
        @(negedge aclk);
        chk("syncerr_cleared", 32'(sync_error), 0);

        // Traffic while hunting for SOF
        base = q.size();
        send(10'h123); send(10'h045);
        send_sync(CODE_EOL);
        send(10'h067);
        send_sync(CODE_EOF);
        send_sync(CODE_SOL);
        send(10'h0AB); send(10'h0CD); send(10'h0EF); send(10'h012);
        idle(6);
        chk("hunt_no_beats", 32'(q.size() - base), 0);
        chk("hunt_syncerr", 32'(sync_error), 0);
        chk("hunt_fcount", 32'(frame_count), 0);

        // Reset mid-line, then a 1x3 frame
        send_sync(CODE_SOF);
        send(10'h0AA); send(10'h0BB);
        do_reset();
        @(negedge aclk);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("mid_rst_linelen", 32'(line_length), 0);
        base = q.size();
        send(10'h0DD);
        send_sync(CODE_SOF);
        send(10'h0C1); send(10'h0C2); send(10'h0C3);
        send_sync(CODE_EOL);
        send_sync(CODE_EOF);
        idle(6);
        chk("rf_beats", 32'(q.size() - base), 3);
        chk("rf_b0", 32'(beat(0)), {16'h0C1, 1'b1, 1'b0});
        chk("rf_b1", 32'(beat(1)), {16'h0C2, 1'b0, 1'b0});
        chk("rf_b2", 32'(beat(2)), {16'h0C3, 1'b0, 1'b1});
        chk("rf_fcount", 32'(frame_count), 1);
        chk("rf_flines", 32'(frame_lines), 1);
        chk("rf_linelen", 32'(line_length), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
